mips_cpu_regfile_sb: RTL and testbench

Parametrised general-purpose register file for the MIPS CPU with two combinational read ports, one architectural write port and a load-fill write port. A per-register scoreboard tracks registers that are the destination of an outstanding memory load, so the control unit can stall on true dependencies. Optional same-cycle write-to-read bypass removes the one-cycle write-then-read hazard. It replaces the fixed 32x32 register file in the CPU datapath.

---
 rtl/mips_cpu_regfile_sb.sv | 117 +++++++++++
 tb/tb_mips_cpu_regfile_sb.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_regfile_sb.sv
// MIPS general-purpose register file with two combinational read ports, an
// architectural write port, a load-fill port and a pending-load scoreboard.
module mips_cpu_regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs_index,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic                  rs_busy,
    input  logic [ADDR_WIDTH-1:0] rt_index,
    output logic [DATA_WIDTH-1:0] rt_data,
    output logic                  rt_busy,
    input  logic                  wr_enable,
    input  logic [ADDR_WIDTH-1:0] wr_index,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  ld_reserve,
    input  logic [ADDR_WIDTH-1:0] ld_reserve_index,
    input  logic                  ld_fill,
    input  logic [ADDR_WIDTH-1:0] ld_fill_index,
    input  logic [DATA_WIDTH-1:0] ld_fill_data,
    output logic [ADDR_WIDTH:0]   pending_count,
    output logic                  fill_err,
    output logic [DATA_WIDTH-1:0] reg_v0
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;
    logic                  wr_act;
    logic                  fill_act;
    logic                  res_act;
    logic [ADDR_WIDTH-1:0] rd_idx  [2];
    logic [DATA_WIDTH-1:0] rd_data [2];
    logic                  rd_busy [2];

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    function automatic logic [ADDR_WIDTH:0] popcount(input logic [DEPTH-1:0] bits);
        logic [ADDR_WIDTH:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt = cnt + {{ADDR_WIDTH{1'b0}}, bits[i]};
        return cnt;
    endfunction

    // Register 0 (when hardwired) swallows every write, fill and reserve.
    assign wr_act   = wr_enable  && !reset && !is_zero(wr_index);
    assign fill_act = ld_fill    && !reset && !is_zero(ld_fill_index);
    assign res_act  = ld_reserve && !reset && !is_zero(ld_reserve_index);

    assign rd_idx[0] = rs_index;
    assign rd_idx[1] = rt_index;
    assign rs_data   = rd_data[0];
    assign rt_data   = rd_data[1];
    assign rs_busy   = rd_busy[0];
    assign rt_busy   = rd_busy[1];
    assign reg_v0    = regs[2];

    // Read ports: architectural write beats fill when both are forwarded.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            // NOTE: every combinational output gets a default first so no latch is inferred.
            rd_data[p] = regs[rd_idx[p]];
            rd_busy[p] = busy[rd_idx[p]];
            if (BYPASS != 0) begin
                if (wr_act && wr_index == rd_idx[p]) begin
                    rd_data[p] = wr_data;
                    rd_busy[p] = 1'b0;
                end else if (fill_act && ld_fill_index == rd_idx[p]) begin
                    rd_data[p] = ld_fill_data;
                    rd_busy[p] = 1'b0;
                end
            end
            if (reset || is_zero(rd_idx[p])) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    // Reserve is applied last so it overrides a same-cycle clear.
    always_comb begin
        busy_next = busy;
        if (fill_act) busy_next[ld_fill_index]    = 1'b0;
        if (wr_act)   busy_next[wr_index]         = 1'b0;
        if (res_act)  busy_next[ld_reserve_index] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is reset because software relies on all registers reading 0.
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy          <= '0;
            pending_count <= '0;
            fill_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates; the later write assignment wins over the fill.
            if (fill_act) regs[ld_fill_index] <= ld_fill_data;
            if (wr_act)   regs[wr_index]      <= wr_data;
            busy          <= busy_next;
            pending_count <= popcount(busy);
            if (fill_act && !busy[ld_fill_index] &&
                !(res_act && ld_reserve_index == ld_fill_index))
                fill_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_cpu_regfile_sb.sv
// Self-checking bench for mips_cpu_regfile_sb: directed scenarios plus a
// randomized run against an array-based reference model.
module tb_mips_cpu_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_index, rt_index, wr_index, ld_reserve_index, ld_fill_index;
    logic        wr_enable, ld_reserve, ld_fill;
    logic [31:0] wr_data, ld_fill_data;
    logic [31:0] rs_data, rt_data, reg_v0;
    logic        rs_busy, rt_busy, fill_err;
    logic [5:0]  pending_count;
    logic [31:0] nb_rs_data, nb_rt_data, nb_reg_v0;
    logic        nb_rs_busy, nb_rt_busy, nb_fill_err;
    logic [5:0]  nb_pending_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          m_err;

    always #5 clk = ~clk;

    mips_cpu_regfile_sb #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset),
        .rs_index(rs_index), .rs_data(rs_data), .rs_busy(rs_busy),
        .rt_index(rt_index), .rt_data(rt_data), .rt_busy(rt_busy),
        .wr_enable(wr_enable), .wr_index(wr_index), .wr_data(wr_data),
        .ld_reserve(ld_reserve), .ld_reserve_index(ld_reserve_index),
        .ld_fill(ld_fill), .ld_fill_index(ld_fill_index), .ld_fill_data(ld_fill_data),
        .pending_count(pending_count), .fill_err(fill_err), .reg_v0(reg_v0)
    );

    mips_cpu_regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset),
        .rs_index(rs_index), .rs_data(nb_rs_data), .rs_busy(nb_rs_busy),
        .rt_index(rt_index), .rt_data(nb_rt_data), .rt_busy(nb_rt_busy),
        .wr_enable(wr_enable), .wr_index(wr_index), .wr_data(wr_data),
        .ld_reserve(ld_reserve), .ld_reserve_index(ld_reserve_index),
        .ld_fill(ld_fill), .ld_fill_index(ld_fill_index), .ld_fill_data(ld_fill_data),
        .pending_count(nb_pending_count), .fill_err(nb_fill_err), .reg_v0(nb_reg_v0)
    );

    // Reference model: commit the cycle's requests in spec order.
    task automatic model_commit();
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'h0;
                m_busy[i] = 1'b0;
            end
            m_err = 1'b0;
            return;
        end
        if (ld_fill && ld_fill_index != 0) begin
            if (!m_busy[ld_fill_index] && !(ld_reserve && ld_reserve_index == ld_fill_index))
                m_err = 1'b1;
            m_regs[ld_fill_index] = ld_fill_data;
            m_busy[ld_fill_index] = 1'b0;
        end
        if (wr_enable && wr_index != 0) begin
            m_regs[wr_index] = wr_data;
            m_busy[wr_index] = 1'b0;
        end
        if (ld_reserve && ld_reserve_index != 0)
            m_busy[ld_reserve_index] = 1'b1;
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (wr_enable && wr_index == idx) return wr_data;
        if (ld_fill && ld_fill_index == idx) return ld_fill_data;
        return m_regs[idx];
    endfunction

    function automatic logic exp_busy(input logic [4:0] idx);
        if (idx == 0) return 1'b0;
        if ((wr_enable && wr_index == idx) || (ld_fill && ld_fill_index == idx)) return 1'b0;
        return m_busy[idx];
    endfunction

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic idle();
        wr_enable = 1'b0; ld_reserve = 1'b0; ld_fill = 1'b0;
        wr_index = '0; ld_reserve_index = '0; ld_fill_index = '0;
        wr_data = '0; ld_fill_data = '0;
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rs_index = '0; rt_index = '0;
        do_reset();
        wr_enable = 1'b1; wr_index = 5'd3; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rs_index = 5'd3;
        #1;
        checks++;
        if (rs_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL reset_prestore got=%h exp=%h", rs_data, 32'hDEADBEEF);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rs_data !== 32'h0 || rs_busy !== 1'b0) begin
            failures++; $display("FAIL reset_forced_read got=%h/%b exp=0/0", rs_data, rs_busy);
        end
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_index = 5'(i);
            rt_index = 5'(31 - i);
            #1;
            checks++;
            if (rs_data !== 32'h0 || rs_busy !== 1'b0 || rt_data !== 32'h0 || rt_busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_read idx=%0d got rs=%h/%b rt=%h/%b exp=0/0", i, rs_data, rs_busy, rt_data, rt_busy);
            end
        end
        checks++;
        if (pending_count !== 6'd0 || fill_err !== 1'b0 || reg_v0 !== 32'h0) begin
            failures++;
            $display("FAIL reset_state got pend=%0d err=%b v0=%h exp=0/0/0", pending_count, fill_err, reg_v0);
        end
    endtask

    task automatic test_bypass();
        wr_enable = 1'b1; wr_index = 5'd5; wr_data = 32'h11111111;
        tick();
        wr_data = 32'h12345678;
        rs_index = 5'd5;
        #1;
        checks++;
        if (rs_data !== exp_data(5'd5)) begin
            failures++; $display("FAIL bypass_same_cycle got=%h exp=%h", rs_data, exp_data(5'd5));
        end
        checks++;
        if (nb_rs_data !== m_regs[5]) begin
            failures++; $display("FAIL nobypass_old got=%h exp=%h", nb_rs_data, m_regs[5]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (nb_rs_data !== 32'h12345678 || rs_data !== 32'h12345678) begin
            failures++; $display("FAIL write_commit got=%h/%h exp=%h", rs_data, nb_rs_data, 32'h12345678);
        end
    endtask

    task automatic test_zero_reg();
        wr_enable = 1'b1; wr_index = 5'd0; wr_data = 32'hFFFFFFFF;
        rs_index = 5'd0;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin
            failures++; $display("FAIL zero_no_bypass got=%h exp=0", rs_data);
        end
        tick();
        idle();
        ld_reserve = 1'b1; ld_reserve_index = 5'd0;
        #1;
        checks++;
        if (rs_data !== 32'h0) begin
            failures++; $display("FAIL zero_after_write got=%h exp=0", rs_data);
        end
        tick();
        idle();
        tick();
        checks++;
        if (rs_busy !== 1'b0 || pending_count !== 6'd0) begin
            failures++; $display("FAIL zero_reserve got busy=%b pend=%0d exp=0/0", rs_busy, pending_count);
        end
    endtask

    task automatic test_scoreboard();
        ld_reserve = 1'b1; ld_reserve_index = 5'd8;
        tick();
        ld_reserve_index = 5'd9;
        tick();
        idle();
        rs_index = 5'd8; rt_index = 5'd9;
        #1;
        checks++;
        if (rs_busy !== 1'b1 || rt_busy !== 1'b1) begin
            failures++; $display("FAIL reserve_busy got=%b/%b exp=1/1", rs_busy, rt_busy);
        end
        tick();
        checks++;
        if (pending_count !== 6'(m_pending())) begin
            failures++; $display("FAIL pending_two got=%0d exp=%0d", pending_count, m_pending());
        end
        ld_fill = 1'b1; ld_fill_index = 5'd8; ld_fill_data = 32'hA5A5A5A5;
        rt_index = 5'd8;
        #1;
        checks++;
        if (rt_busy !== 1'b0 || rt_data !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL fill_bypass got=%h/%b exp=%h/0", rt_data, rt_busy, 32'hA5A5A5A5);
        end
        tick();
        idle();
        tick();
        checks++;
        if (pending_count !== 6'd1 || rt_busy !== 1'b0 || rt_data !== 32'hA5A5A5A5 || fill_err !== 1'b0) begin
            failures++;
            $display("FAIL fill_commit got pend=%0d busy=%b data=%h err=%b exp=1/0/a5a5a5a5/0", pending_count, rt_busy, rt_data, fill_err);
        end
    endtask

    task automatic test_reserve_fill_same();
        ld_reserve = 1'b1; ld_reserve_index = 5'd8;
        tick();
        idle();
        tick();
        ld_reserve = 1'b1; ld_reserve_index = 5'd8;
        ld_fill = 1'b1; ld_fill_index = 5'd8; ld_fill_data = 32'h5A5A0001;
        tick();
        idle();
        rs_index = 5'd8;
        #1;
        checks++;
        if (rs_busy !== 1'b1 || rs_data !== 32'h5A5A0001 || fill_err !== 1'b0) begin
            failures++;
            $display("FAIL reserve_fill_same got busy=%b data=%h err=%b exp=1/5a5a0001/0", rs_busy, rs_data, fill_err);
        end
        tick();
        checks++;
        if (pending_count !== 6'd2) begin
            failures++; $display("FAIL reserve_fill_pending got=%0d exp=2", pending_count);
        end
    endtask

    task automatic test_fill_err();
        ld_fill = 1'b1; ld_fill_index = 5'd12; ld_fill_data = 32'hC0FFEE12;
        tick();
        idle();
        rs_index = 5'd12;
        #1;
        checks++;
        if (fill_err !== 1'b1 || rs_data !== 32'hC0FFEE12) begin
            failures++; $display("FAIL fill_err_set got err=%b data=%h exp=1/c0ffee12", fill_err, rs_data);
        end
        ld_fill = 1'b1; ld_fill_index = 5'd9; ld_fill_data = 32'h99;
        tick();
        idle();
        wr_enable = 1'b1; wr_index = 5'd2; wr_data = 32'd7;
        #1;
        checks++;
        if (reg_v0 !== 32'h0) begin
            failures++; $display("FAIL reg_v0_no_bypass got=%h exp=0", reg_v0);
        end
        tick();
        idle();
        checks++;
        if (reg_v0 !== 32'd7 || fill_err !== 1'b1) begin
            failures++; $display("FAIL reg_v0_sticky got v0=%h err=%b exp=7/1", reg_v0, fill_err);
        end
        do_reset();
        checks++;
        if (fill_err !== 1'b0) begin
            failures++; $display("FAIL fill_err_clear got=%b exp=0", fill_err);
        end
    endtask

    task automatic test_random();
        int prev_pc;
        int pc;
        do_reset();
        prev_pc = 0;
        for (int n = 0; n < 400; n++) begin
            idle();
            wr_enable = ($urandom_range(0, 9) < 3);
            wr_index = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            ld_reserve = ($urandom_range(0, 9) < 3);
            ld_reserve_index = 5'($urandom_range(0, 31));
            ld_fill = ($urandom_range(0, 9) < 3);
            ld_fill_index = 5'($urandom_range(1, 31));
            if ($urandom_range(0, 9) < 8) begin
                int start = $urandom_range(1, 31);
                for (int k = 0; k < 31; k++) begin
                    int j = 1 + ((start - 1 + k) % 31);
                    if (m_busy[j]) begin
                        ld_fill_index = 5'(j);
                        break;
                    end
                end
            end
            ld_fill_data = $urandom;
            rs_index = ($urandom_range(0, 3) == 0) ? wr_index : 5'($urandom_range(0, 31));
            rt_index = ($urandom_range(0, 3) == 0) ? ld_fill_index : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (rs_data !== exp_data(rs_index) || rs_busy !== exp_busy(rs_index)) begin
                failures++;
                $display("FAIL rand_rs n=%0d idx=%0d got=%h/%b exp=%h/%b", n, rs_index, rs_data, rs_busy, exp_data(rs_index), exp_busy(rs_index));
            end
            checks++;
            if (rt_data !== exp_data(rt_index) || rt_busy !== exp_busy(rt_index)) begin
                failures++;
                $display("FAIL rand_rt n=%0d idx=%0d got=%h/%b exp=%h/%b", n, rt_index, rt_data, rt_busy, exp_data(rt_index), exp_busy(rt_index));
            end
            tick();
            checks++;
            if (fill_err !== m_err || reg_v0 !== m_regs[2]) begin
                failures++;
                $display("FAIL rand_state n=%0d got err=%b v0=%h exp=%b/%h", n, fill_err, reg_v0, m_err, m_regs[2]);
            end
            pc = m_pending();
            if (pc == prev_pc) begin
                checks++;
                if (pending_count !== 6'(pc)) begin
                    failures++; $display("FAIL rand_pending n=%0d got=%0d exp=%0d", n, pending_count, pc);
                end
            end
            prev_pc = pc;
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_reserve_fill_same();
        test_fill_err();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
